// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Width of the channel-index field; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Register-side bus of the PWM block: configuration, duty writes and status.
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic                  enable;
  logic                  center_mode;
  logic [PRESCALE_W-1:0] prescale;
  logic                  duty_wr;
  logic [CH_W-1:0]       duty_ch;
  logic [WIDTH-1:0]      duty_val;
  logic [NUM_CH-1:0]     invert;
  logic [NUM_CH-1:0]     pwm_out;
  logic                  period_start;
  logic                  update_pending;

  modport master (
    output enable, center_mode, prescale, duty_wr, duty_ch, duty_val, invert,
    input  pwm_out, period_start, update_pending
  );

  modport slave (
    input  enable, center_mode, prescale, duty_wr, duty_ch, duty_val, invert,
    output pwm_out, period_start, update_pending
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every prescale+1 enabled clocks.
module pwm_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  // >= rather than == so lowering prescale mid-count wraps at once.
  assign tick = enable && (pcnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (!enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/centre-aligned counter, double-buffered duties
// loaded atomically at the period boundary, registered per-channel outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic  clk,
  input  logic  reset,
  pwm_if.slave  bus
);

  localparam int               CH_W    = ch_idx_w(NUM_CH);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic              tick;
  logic              boundary;
  logic [WIDTH-1:0]  cnt;
  dir_t              dir;
  logic              mode_q;
  logic [NUM_CH-1:0] below;
  logic [NUM_CH-1:0] differs;

  pwm_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  // Edge mode ends on the tick at the top; centre mode on the tick that takes DOWN from 1 to 0.
  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (mode_q == MODE_EDGE) begin
        boundary = (cnt == CNT_MAX);
      end else begin
        boundary = (dir == DIR_DOWN) && (cnt == CNT_ONE);
      end
    end
  end

  // Counter / direction FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      dir            <= DIR_UP;
      mode_q         <= MODE_EDGE;
      pwm_out_clear();
    end else begin
      bus.pwm_out        <= bus.enable ? (below ^ bus.invert) : bus.invert;
      bus.period_start   <= boundary;
      bus.update_pending <= |differs;
      if (!bus.enable || boundary) begin
        cnt    <= '0;
        dir    <= DIR_UP;
        mode_q <= bus.center_mode;
      end else if (tick) begin
        if (mode_q == MODE_EDGE) begin
          cnt <= cnt + 1'b1;
        end else begin
          case (dir)
            DIR_UP: begin
              if (cnt == CNT_MAX) begin
                dir <= DIR_DOWN;
                cnt <= cnt - 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            DIR_DOWN: begin
              cnt <= cnt - 1'b1;
            end
            default: begin
              dir <= DIR_UP;
            end
          endcase
        end
      end
    end
  end

  task automatic pwm_out_clear();
    bus.pwm_out        <= '0;
    bus.period_start   <= 1'b0;
    bus.update_pending <= 1'b0;
  endtask

  // Per-channel shadow/active duty pair and compare.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;
    logic             wr_hit;

    // Widened match means an index >= NUM_CH selects no channel.
    assign wr_hit = bus.duty_wr && ({1'b0, bus.duty_ch} == (CH_W+1)'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (wr_hit) begin
          shadow_q <= bus.duty_val;
        end
        if (!bus.enable || boundary) begin
          active_q <= shadow_q;
        end
      end
    end

    assign below[i]   = (cnt < active_q);
    assign differs[i] = (shadow_q != active_q);
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed period/duty scenarios plus randomized traffic
// compared every cycle against a period-position reference model.
`timescale 1ns/1ps
module tb_pwm_multi;

  localparam int NUM_CH     = 4;
  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 16;
  localparam int MAXV       = (1 << WIDTH) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pwm_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus  ();
  pwm_if #(.NUM_CH(3),      .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus3 ();

  pwm_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pwm_multi #(.NUM_CH(3), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: position t (in ticks) inside the current period.
  int                m_pcnt = 0;
  int                m_t    = 0;
  bit                m_mode = 1'b0;
  int                m_sh [NUM_CH] = '{default: 0};
  int                m_ac [NUM_CH] = '{default: 0};
  logic [NUM_CH-1:0] m_pwm  = '0;
  logic              m_ps   = 1'b0;
  logic              m_pend = 1'b0;

  function automatic int cnt_of(input int t, input bit mode);
    if (!mode || t <= MAXV) return t;
    return 2 * MAXV - t;
  endfunction

  always @(posedge clk) begin : ref_model
    int                plen;
    bit                tk;
    bit                bnd;
    bit                npend;
    logic [NUM_CH-1:0] npwm;
    if (reset) begin
      m_pcnt <= 0;
      m_t    <= 0;
      m_mode <= 1'b0;
      m_pwm  <= '0;
      m_ps   <= 1'b0;
      m_pend <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh[i] <= 0;
        m_ac[i] <= 0;
      end
    end else begin
      npend = 1'b0;
      npwm  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        npend   = npend | (m_sh[i] != m_ac[i]);
        npwm[i] = bus.enable ? ((cnt_of(m_t, m_mode) < m_ac[i]) ^ bus.invert[i]) : bus.invert[i];
      end
      plen = m_mode ? 2 * MAXV : MAXV + 1;
      tk   = bus.enable && (m_pcnt >= int'(bus.prescale));
      bnd  = tk && (m_t == plen - 1);
      m_pwm  <= npwm;
      m_pend <= npend;
      m_ps   <= bnd;
      if (!bus.enable || bnd) begin
        m_t    <= 0;
        m_mode <= bus.center_mode;
        for (int i = 0; i < NUM_CH; i++) m_ac[i] <= m_sh[i];
      end else if (tk) begin
        m_t <= m_t + 1;
      end
      m_pcnt <= (!bus.enable || tk) ? 0 : m_pcnt + 1;
      if (bus.duty_wr) m_sh[bus.duty_ch] <= int'(bus.duty_val);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle", {bus.pwm_out, bus.period_start, bus.update_pending}, {m_pwm, m_ps, m_pend});
    end
  end

  int mlen;
  int mhalf;
  int mh [NUM_CH];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int v);
    bus.duty_wr  = 1'b1;
    bus.duty_ch  = 2'(ch);
    bus.duty_val = 8'(v);
    @(negedge clk);
    bus.duty_wr  = 1'b0;
  endtask

  task automatic wr3(input int ch, input int v);
    bus3.duty_wr  = 1'b1;
    bus3.duty_ch  = 2'(ch);
    bus3.duty_val = 8'(v);
    @(negedge clk);
    bus3.duty_wr  = 1'b0;
  endtask

  task automatic wait_ps(input string tag, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.period_start && n < limit);
    if (!bus.period_start) chk({tag, "_tmo"}, bus.period_start, 1);
  endtask

  // Samples from the cycle after a period_start up to and including the next one.
  task automatic measure(input string tag);
    mlen  = 0;
    mhalf = 0;
    for (int i = 0; i < NUM_CH; i++) mh[i] = 0;
    do begin
      @(negedge clk);
      mlen++;
      for (int i = 0; i < NUM_CH; i++) if (bus.pwm_out[i]) mh[i]++;
      if (mlen <= MAXV && bus.pwm_out[0]) mhalf++;
    end while (!bus.period_start && mlen < 5000);
    if (!bus.period_start) chk({tag, "_tmo"}, bus.period_start, 1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.enable = 1'b0;  bus.center_mode = 1'b0; bus.prescale = '0;
    bus.duty_wr = 1'b0; bus.duty_ch = '0;       bus.duty_val = '0; bus.invert = '0;
    bus3.enable = 1'b0; bus3.center_mode = 1'b0; bus3.prescale = '0;
    bus3.duty_wr = 1'b0; bus3.duty_ch = '0;      bus3.duty_val = '0; bus3.invert = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_pwm",  bus.pwm_out, 0);
    chk("rst_ps",   bus.period_start, 0);
    chk("rst_pend", bus.update_pending, 0);

    // Edge mode, prescale 0, boundary duties.
    bus.enable = 1'b1;
    bus.invert = 4'b1000;
    wr(0, 64); wr(1, 0); wr(2, 255); wr(3, 0);
    wait_ps("e1_sync", 400, n);
    measure("e1");
    chk("e1_len", mlen, 256);
    chk("e1_ch0", mh[0], 64);
    chk("e1_ch1", mh[1], 0);
    chk("e1_ch2", mh[2], 255);
    chk("e1_ch3", mh[3], 256);
    measure("e1b");
    chk("e1b_len", mlen, 256);

    // Prescale 3, half duty.
    bus.prescale = 16'd3;
    wr(0, 128);
    wait_ps("p3_sync", 2000, n);
    measure("p3");
    chk("p3_len", mlen, 1024);
    chk("p3_hi",  mh[0], 512);

    // Prescale lowered from 100 to 2 with pcnt at 50.
    bus.prescale = 16'd100;
    cyc(50);
    bus.prescale = 16'd2;
    wait_ps("pchg", 2000, n);
    chk("pchg_len", n, 766);

    // Centre-aligned mode.
    bus.prescale    = 16'd0;
    bus.center_mode = 1'b1;
    wr(0, 100);
    wait_ps("c_sync", 2000, n);
    measure("c");
    chk("c_len",   mlen, 510);
    chk("c_ch0",   mh[0], 199);
    chk("c_half",  mhalf, 100);
    chk("c_ch1",   mh[1], 0);
    chk("c_ch2",   mh[2], 509);
    chk("c_ch3",   mh[3], 510);

    // Coherent update mid-period, back in edge mode.
    bus.center_mode = 1'b0;
    wait_ps("u_sync", 1000, n);
    cyc(20);
    wr(0, 200);
    cyc(1);
    chk("u_pend1", bus.update_pending, 1);
    measure("u_old");
    chk("u_old_len", mlen, 234);
    chk("u_old_hi",  mh[0], 78);
    cyc(1);
    chk("u_pend0", bus.update_pending, 0);
    measure("u_new");
    chk("u_new_len", mlen, 255);
    chk("u_new_hi",  mh[0], 199);

    // Write landing on the boundary cycle.
    cyc(255);
    wr(0, 30);
    chk("wb_ps", bus.period_start, 1);
    measure("wb1");
    chk("wb1_hi", mh[0], 200);
    measure("wb2");
    chk("wb2_hi", mh[0], 30);

    // Reset mid-period.
    cyc(100);
    wr(1, 9);
    cyc(1);
    chk("mr_pend_before", bus.update_pending, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_pwm",  bus.pwm_out, 0);
    chk("mr_ps",   bus.period_start, 0);
    chk("mr_pend", bus.update_pending, 0);
    reset = 1'b0;

    // Out-of-range channel index on a 3-channel instance.
    bus3.enable = 1'b1;
    wr3(3, 77);
    cyc(3);
    chk("bad_ch_pend", bus3.update_pending, 0);
    chk("bad_ch_pwm",  bus3.pwm_out, 0);
    wr3(2, 5);
    cyc(1);
    chk("ok_ch_pend",  bus3.update_pending, 1);

    // Randomized traffic, checked every cycle against the model.
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      bus.duty_wr = 1'b0;
      reset = ($urandom_range(0, 2499) == 0);
      if ($urandom_range(0, 399) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 24) == 0) begin
        bus.duty_wr = 1'b1;
        bus.duty_ch = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       bus.duty_val = 8'd0;
          1:       bus.duty_val = 8'd255;
          default: bus.duty_val = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 299) == 0) bus.prescale = 16'($urandom_range(0, 2));
      if ($urandom_range(0, 249) == 0) bus.center_mode = ~bus.center_mode;
      if ($urandom_range(0, 299) == 0) bus.invert = 4'($urandom);
    end
    @(negedge clk);
    bus.duty_wr = 1'b0;
    reset = 1'b0;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
